// File: rtl/regfile_wr_arbiter_if.sv
// Request/acknowledge and register-file write bundle shared by requesters A and B
// and the round-robin write-port arbiter.
interface regfile_wr_arbiter_if;
    logic       a_req;
    logic [1:0] a_reg;
    logic [2:0] a_data;
    logic       a_ack;
    logic       a_err;
    logic       b_req;
    logic [1:0] b_reg;
    logic [2:0] b_data;
    logic       b_ack;
    logic       b_err;
    logic       wr_en;
    logic [1:0] wr_reg;
    logic [2:0] wr_data;
    logic       busy;
    logic       last_grant;

    modport master (
        output a_req, a_reg, a_data, b_req, b_reg, b_data,
        input  a_ack, a_err, b_ack, b_err, wr_en, wr_reg, wr_data, busy, last_grant
    );

    modport slave (
        input  a_req, a_reg, a_data, b_req, b_reg, b_data,
        output a_ack, a_err, b_ack, b_err, wr_en, wr_reg, wr_data, busy, last_grant
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port between requesters A and B,
// with a fixed turnaround gap after each service so the negedge write can settle.
module regfile_wr_arbiter #(
    parameter int NUM_REGS    = 3,
    parameter int COOL_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    regfile_wr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        COOL  = 2'd2
    } state_t;

    localparam logic [1:0] COOL_LOAD = (COOL_CYCLES > 0) ? 2'(COOL_CYCLES - 1) : 2'd0;

    function automatic logic in_range(input logic [1:0] idx);
        return (int'({30'd0, idx}) < NUM_REGS);
    endfunction

    state_t     state_r;
    logic [1:0] cool_cnt_r;
    logic       a_ack_r;
    logic       a_err_r;
    logic       b_ack_r;
    logic       b_err_r;
    logic       wr_en_r;
    logic [1:0] wr_reg_r;
    logic [2:0] wr_data_r;
    logic       busy_r;
    logic       last_grant_r;

    logic       any_req_s;
    logic       pick_b_s;
    logic [1:0] sel_reg_s;
    logic [2:0] sel_data_s;
    logic       sel_ok_s;

    // Winner selection: on a tie, the requester that was not served last wins.
    always_comb begin
        any_req_s = bus.a_req | bus.b_req;
        if (bus.a_req && bus.b_req) begin
            pick_b_s = ~last_grant_r;
        end else begin
            pick_b_s = bus.b_req;
        end
        if (pick_b_s) begin
            sel_reg_s  = bus.b_reg;
            sel_data_s = bus.b_data;
        end else begin
            sel_reg_s  = bus.a_reg;
            sel_data_s = bus.a_data;
        end
        sel_ok_s = in_range(sel_reg_s);
    end

    // Arbiter FSM; all outputs registered, strobes launched at the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cool_cnt_r   <= 2'd0;
            a_ack_r      <= 1'b0;
            a_err_r      <= 1'b0;
            b_ack_r      <= 1'b0;
            b_err_r      <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_reg_r     <= 2'd0;
            wr_data_r    <= 3'd0;
            busy_r       <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            a_ack_r <= 1'b0;
            a_err_r <= 1'b0;
            b_ack_r <= 1'b0;
            b_err_r <= 1'b0;
            wr_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r      <= WRITE;
                        busy_r       <= 1'b1;
                        last_grant_r <= pick_b_s;
                        a_ack_r      <= ~pick_b_s;
                        b_ack_r      <= pick_b_s;
                        a_err_r      <= ~pick_b_s & ~sel_ok_s;
                        b_err_r      <= pick_b_s & ~sel_ok_s;
                        wr_en_r      <= sel_ok_s;
                        // Out-of-range writes leave the last good index/data on the port.
                        if (sel_ok_s) begin
                            wr_reg_r  <= sel_reg_s;
                            wr_data_r <= sel_data_s;
                        end else begin
                            wr_reg_r  <= wr_reg_r;
                            wr_data_r <= wr_data_r;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (COOL_CYCLES > 0) begin
                        state_r    <= COOL;
                        cool_cnt_r <= COOL_LOAD;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                COOL: begin
                    if (cool_cnt_r == 2'd0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cool_cnt_r <= cool_cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cool_cnt_r <= 2'd0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_ack      = a_ack_r;
    assign bus.a_err      = a_err_r;
    assign bus.b_ack      = b_ack_r;
    assign bus.b_err      = b_err_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_reg     = wr_reg_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.busy       = busy_r;
    assign bus.last_grant = last_grant_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: one instance with COOL_CYCLES=1 and one with
// COOL_CYCLES=0, plus a small negedge-written register file model.
module tb_regfile_wr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    regfile_wr_arbiter_if bus1 ();
    regfile_wr_arbiter_if bus0 ();

    regfile_wr_arbiter #(.NUM_REGS(3), .COOL_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    regfile_wr_arbiter #(.NUM_REGS(3), .COOL_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    logic [2:0] rf [0:3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file samples the strobe on the falling edge.
    always @(negedge clk) begin
        if (bus1.wr_en === 1'b1) rf[bus1.wr_reg] <= bus1.wr_data;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.a_req = 1'b0; bus1.a_reg = 2'd0; bus1.a_data = 3'd0;
        bus1.b_req = 1'b0; bus1.b_reg = 2'd0; bus1.b_data = 3'd0;
        bus0.a_req = 1'b0; bus0.a_reg = 2'd0; bus0.a_data = 3'd0;
        bus0.b_req = 1'b0; bus0.b_reg = 2'd0; bus0.b_data = 3'd0;
        step(); step();
        checks++; if (bus1.wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", bus1.wr_en); else passes++;
        checks++; if (bus1.wr_reg !== 2'd0 || bus1.wr_data !== 3'd0) $display("FAIL rst_wr_bus: got %0d/%0d want 0/0", bus1.wr_reg, bus1.wr_data); else passes++;
        checks++; if ({bus1.a_ack, bus1.a_err, bus1.b_ack, bus1.b_err} !== 4'b0000) $display("FAIL rst_acks: got %b want 0000", {bus1.a_ack, bus1.a_err, bus1.b_ack, bus1.b_err}); else passes++;
        checks++; if (bus1.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus1.busy); else passes++;
        checks++; if (bus1.last_grant !== 1'b1) $display("FAIL rst_last_grant: got %b want 1", bus1.last_grant); else passes++;
        checks++; if (bus0.busy !== 1'b0 || bus0.last_grant !== 1'b1) $display("FAIL rst_dut0: got busy=%b lg=%b want 0/1", bus0.busy, bus0.last_grant); else passes++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        bus1.a_req = 1'b1; bus1.a_reg = 2'd2; bus1.a_data = 3'd5;
        step();
        checks++; if (bus1.wr_en !== 1'b1) $display("FAIL single_wr_en: got %b want 1", bus1.wr_en); else passes++;
        checks++; if (bus1.wr_reg !== 2'd2 || bus1.wr_data !== 3'd5) $display("FAIL single_payload: got %0d/%0d want 2/5", bus1.wr_reg, bus1.wr_data); else passes++;
        checks++; if (bus1.a_ack !== 1'b1 || bus1.a_err !== 1'b0 || bus1.b_ack !== 1'b0) $display("FAIL single_ack: got a_ack=%b a_err=%b b_ack=%b want 1/0/0", bus1.a_ack, bus1.a_err, bus1.b_ack); else passes++;
        checks++; if (bus1.busy !== 1'b1 || bus1.last_grant !== 1'b0) $display("FAIL single_busy_lg: got %b/%b want 1/0", bus1.busy, bus1.last_grant); else passes++;
        bus1.a_req = 1'b0;
        step();
        checks++; if (bus1.wr_en !== 1'b0 || bus1.a_ack !== 1'b0 || bus1.busy !== 1'b1) $display("FAIL single_cool: got wr_en=%b a_ack=%b busy=%b want 0/0/1", bus1.wr_en, bus1.a_ack, bus1.busy); else passes++;
        checks++; if (rf[2] !== 3'd5) $display("FAIL single_rf: got %0d want 5", rf[2]); else passes++;
        step();
        checks++; if (bus1.wr_en !== 1'b0 || bus1.busy !== 1'b0) $display("FAIL single_idle: got wr_en=%b busy=%b want 0/0", bus1.wr_en, bus1.busy); else passes++;
    endtask

    task automatic test_alternate();
        logic exp_a;
        logic exp_b;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus1.a_req = 1'b1; bus1.a_reg = 2'd0; bus1.a_data = 3'd3;
        bus1.b_req = 1'b1; bus1.b_reg = 2'd1; bus1.b_data = 3'd4;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_a = ((i % 6) == 1);
            exp_b = ((i % 6) == 4);
            checks++; if (bus1.a_ack !== exp_a || bus1.b_ack !== exp_b) $display("FAIL alt_acks cycle %0d: got a=%b b=%b want a=%b b=%b", i, bus1.a_ack, bus1.b_ack, exp_a, exp_b); else passes++;
            checks++; if (bus1.wr_en !== (exp_a | exp_b)) $display("FAIL alt_wr_en cycle %0d: got %b want %b", i, bus1.wr_en, exp_a | exp_b); else passes++;
            if (exp_a) begin
                checks++; if (bus1.wr_reg !== 2'd0 || bus1.wr_data !== 3'd3) $display("FAIL alt_payload_a cycle %0d: got %0d/%0d want 0/3", i, bus1.wr_reg, bus1.wr_data); else passes++;
            end else if (exp_b) begin
                checks++; if (bus1.wr_reg !== 2'd1 || bus1.wr_data !== 3'd4) $display("FAIL alt_payload_b cycle %0d: got %0d/%0d want 1/4", i, bus1.wr_reg, bus1.wr_data); else passes++;
            end
        end
        bus1.a_req = 1'b0;
        bus1.b_req = 1'b0;
        step();
        checks++; if (bus1.busy !== 1'b0 || bus1.last_grant !== 1'b1) $display("FAIL alt_end: got busy=%b lg=%b want 0/1", bus1.busy, bus1.last_grant); else passes++;
    endtask

    task automatic test_out_of_range();
        bus1.b_req = 1'b1; bus1.b_reg = 2'd3; bus1.b_data = 3'd7;
        step();
        checks++; if (bus1.b_ack !== 1'b1 || bus1.b_err !== 1'b1) $display("FAIL oor_ack_err: got %b/%b want 1/1", bus1.b_ack, bus1.b_err); else passes++;
        checks++; if (bus1.wr_en !== 1'b0 || bus1.a_ack !== 1'b0 || bus1.a_err !== 1'b0) $display("FAIL oor_wr_en: got wr_en=%b a_ack=%b a_err=%b want 0/0/0", bus1.wr_en, bus1.a_ack, bus1.a_err); else passes++;
        checks++; if (bus1.wr_reg !== 2'd1 || bus1.wr_data !== 3'd4) $display("FAIL oor_hold: got %0d/%0d want 1/4", bus1.wr_reg, bus1.wr_data); else passes++;
        bus1.b_req = 1'b0;
        step();
        checks++; if (rf[0] !== 3'd3 || rf[1] !== 3'd4 || rf[2] !== 3'd5) $display("FAIL oor_rf: got %0d,%0d,%0d want 3,4,5", rf[0], rf[1], rf[2]); else passes++;
        checks++; if (bus1.b_ack !== 1'b0 || bus1.b_err !== 1'b0) $display("FAIL oor_pulse_width: got %b/%b want 0/0", bus1.b_ack, bus1.b_err); else passes++;
        step();
    endtask

    task automatic test_capture();
        bus1.a_req = 1'b1; bus1.a_reg = 2'd1; bus1.a_data = 3'd1;
        step();
        bus1.a_data = 3'd6;
        checks++; if (bus1.a_ack !== 1'b1 || bus1.wr_data !== 3'd1) $display("FAIL cap_first: got ack=%b data=%0d want 1/1", bus1.a_ack, bus1.wr_data); else passes++;
        step();
        checks++; if (bus1.wr_en !== 1'b0 || bus1.wr_data !== 3'd1) $display("FAIL cap_hold: got wr_en=%b data=%0d want 0/1", bus1.wr_en, bus1.wr_data); else passes++;
        checks++; if (rf[1] !== 3'd1) $display("FAIL cap_rf: got %0d want 1", rf[1]); else passes++;
        step();
        checks++; if (bus1.a_ack !== 1'b0 || bus1.busy !== 1'b0) $display("FAIL cap_idle: got ack=%b busy=%b want 0/0", bus1.a_ack, bus1.busy); else passes++;
        step();
        checks++; if (bus1.a_ack !== 1'b1 || bus1.wr_en !== 1'b1 || bus1.wr_data !== 3'd6) $display("FAIL cap_requeue: got ack=%b en=%b data=%0d want 1/1/6", bus1.a_ack, bus1.wr_en, bus1.wr_data); else passes++;
        bus1.a_req = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_in_cool();
        bus1.a_req = 1'b1; bus1.a_reg = 2'd0; bus1.a_data = 3'd2;
        step();
        checks++; if (bus1.a_ack !== 1'b1) $display("FAIL rc_a_ack: got %b want 1", bus1.a_ack); else passes++;
        bus1.a_req = 1'b0;
        bus1.b_req = 1'b1; bus1.b_reg = 2'd2; bus1.b_data = 3'd3;
        step();
        checks++; if (bus1.busy !== 1'b1 || bus1.last_grant !== 1'b0) $display("FAIL rc_in_cool: got busy=%b lg=%b want 1/0", bus1.busy, bus1.last_grant); else passes++;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus1.b_ack !== 1'b0 || bus1.wr_en !== 1'b0 || bus1.busy !== 1'b0) $display("FAIL rc_held %0d: got ack=%b en=%b busy=%b want 0/0/0", i, bus1.b_ack, bus1.wr_en, bus1.busy); else passes++;
            checks++; if (bus1.last_grant !== 1'b1) $display("FAIL rc_lg %0d: got %b want 1", i, bus1.last_grant); else passes++;
        end
        rst = 1'b0;
        step();
        checks++; if (bus1.b_ack !== 1'b1 || bus1.busy !== 1'b1 || bus1.wr_en !== 1'b1) $display("FAIL rc_b_grant: got ack=%b busy=%b en=%b want 1/1/1", bus1.b_ack, bus1.busy, bus1.wr_en); else passes++;
        checks++; if (bus1.wr_reg !== 2'd2 || bus1.wr_data !== 3'd3) $display("FAIL rc_b_payload: got %0d/%0d want 2/3", bus1.wr_reg, bus1.wr_data); else passes++;
        bus1.b_req = 1'b0;
        step(); step();
    endtask

    task automatic test_no_cool();
        logic exp;
        bus0.a_req = 1'b1; bus0.a_reg = 2'd1; bus0.a_data = 3'd3;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp = ((i % 2) == 1);
            checks++; if (bus0.wr_en !== exp || bus0.a_ack !== exp) $display("FAIL nocool cycle %0d: got en=%b ack=%b want %b", i, bus0.wr_en, bus0.a_ack, exp); else passes++;
            checks++; if (bus0.busy !== exp) $display("FAIL nocool_busy cycle %0d: got %b want %b", i, bus0.busy, exp); else passes++;
        end
        bus0.a_req = 1'b0;
        step(); step();
        checks++; if (bus0.wr_en !== 1'b0 || bus0.busy !== 1'b0) $display("FAIL nocool_end: got en=%b busy=%b want 0/0", bus0.wr_en, bus0.busy); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_single_write();
        test_alternate();
        test_out_of_range();
        test_capture();
        test_reset_in_cool();
        test_no_cool();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin arbiter that shares the register file's single write port between two requesters, A and B. Each requester presents a write (register index plus 3-bit data) with a level request. The arbiter picks one, drives one registered write strobe into the register file, acknowledges the winner, and inserts a programmable turnaround gap. That gap lets the register file's negedge write settle before the next write. Out-of-range register indices are acknowledged with an error and never reach the register file.

## Interface

Parameters:
- NUM_REGS, default 3: number of implemented registers; valid indices are 0..NUM_REGS-1.
- COOL_CYCLES, default 1: idle cycles inserted after every serviced request (0..3).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  requester A write request (level).
- a_reg  in  2  requester A target register index.
- a_data  in  3  requester A write data.
- a_ack  out  1  one-cycle pulse: A's request serviced.
- a_err  out  1  one-cycle pulse with a_ack: A's index was out of range, write dropped.
- b_req, b_reg, b_data, b_ack, b_err: same as the A group, for requester B.
- wr_en  out  1  write strobe to the register file.
- wr_reg  out  2  write index to the register file.
- wr_data  out  3  write data to the register file.
- busy  out  1  high in every state except IDLE.
- last_grant  out  1  0 = A served last, 1 = B served last.

## Operation

State machine with three states: IDLE, WRITE, COOL.

IDLE:
- Sample a_req and b_req.
- Neither asserted: stay in IDLE.
- Exactly one asserted: select it.
- Both asserted: select the requester not equal to last_grant's owner. last_grant=1 selects A; last_grant=0 selects B.
- On selection, capture the winner's reg/data into internal registers, update last_grant, and go to WRITE.
- Payload is captured only at this edge. Changes afterwards are ignored.

WRITE (exactly 1 cycle):
- Winner's ack = 1.
- If the captured index is < NUM_REGS: wr_en = 1, and wr_reg/wr_data = captured values.
- Otherwise: wr_en = 0, the winner's err = 1, and the register file is untouched.
- Next state: COOL if COOL_CYCLES > 0, else IDLE.

COOL:
- Down-counter loaded with COOL_CYCLES-1 on entry. Exit to IDLE when the counter reads 0.
- wr_en = 0, and both acks are 0.

Requester rules:
- Hold req and payload stable until ack.
- Deassert req in the cycle after ack, or keep it high to queue a new request. A req still high on return to IDLE counts as a new request.
- A req withdrawn before the IDLE capture edge is simply not serviced.

Outputs:
- wr_en, wr_reg, wr_data, acks, errs and busy are all registered. No combinational path exists from any input to any output.
- wr_reg and wr_data hold their last values while wr_en = 0.

Reset:
- When rst = 1 at a posedge, the next state is IDLE.
- All outputs go to 0: wr_en, wr_reg, wr_data, a_ack, a_err, b_ack, b_err, busy.
- last_grant goes to 1, so A wins the first tie.
- The cool counter clears to 0.
- Reset mid-WRITE or mid-COOL abandons the operation: no ack is issued afterwards. A write strobe already presented in that cycle is not retracted.
- Requests held through reset are re-arbitrated from IDLE.

## Timing

- Latency: req sampled high in IDLE at edge N gives ack and wr_en high during cycle N+1, i.e. registered at edge N.
- Service period: 2 + COOL_CYCLES cycles per request. With the default this is 3 cycles, so 1 write per 3 cycles.
- Both requesters continuously requesting: grants strictly alternate A, B, A, B…, starting with A after reset.
- wr_en is never high in two consecutive cycles when COOL_CYCLES ≥ 1. With COOL_CYCLES = 0 the minimum gap is 1 cycle (the IDLE cycle).
- ack/err are exactly 1 cycle wide and never asserted for both requesters in the same cycle.
- busy rises at the same edge wr_en does and falls on the edge returning to IDLE.

## Test plan

1. Reset with COOL_CYCLES=1: all outputs 0 and last_grant=1. Then a_req=1, a_reg=2, a_data=5 → next cycle wr_en=1, wr_reg=2, wr_data=5, a_ack=1. wr_en is low for the following 2 cycles.
2. a_req and b_req both held high with different payloads for 12 cycles → acks in order A, B, A, B with 3-cycle spacing. wr_data matches each owner's payload. Never both acks at once.
3. b_req=1, b_reg=3, b_data=7 (NUM_REGS=3) → b_ack=1 and b_err=1 in the same cycle, wr_en stays 0, and the register file contents are unchanged.
4. a_data changed from 1 to 6 one cycle after grant capture → wr_data=1 is written (captured value, not the new one).
5. rst asserted during COOL after an A write, with b_req high → no ack issued while in reset. After release: IDLE, then a B grant on the next edge, with busy=1.
6. COOL_CYCLES=0, a_req held high continuously → wr_en pulses every 2nd cycle and a_ack accompanies each pulse.
